// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan driver.
package seg_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low patterns {dp,g,f,e,d,c,b,a}: 0-9, A, b, C, d, E, F.
  localparam logic [7:0] SEG_HEX [0:15] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment decoder, dp held off.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed hex display driver: latches a 32-bit word and scans it across
// a common-anode bank with a blanking gap between digits.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int CLK_DIV    = 50000,
  parameter int NUM_DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           data_in,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  scan_state_t           state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [31:0]           hold_q, hold_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_q, frame_d;

  logic [NUM_DIGITS-1:0] nz_from;
  logic [NUM_DIGITS-1:0] an_sel;
  logic [3:0]            nibble_sel;
  logic                  lz_sel;
  logic [7:0]            dec_seg;

  // nz_from[i] is set when any nibble i..NUM_DIGITS-1 of the held word is nonzero.
  always_comb begin
    logic acc;
    acc     = 1'b0;
    nz_from = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      acc        = acc | (|hold_q[4*i +: 4]);
      nz_from[i] = acc;
    end
  end

  always_comb begin
    an_sel     = '1;
    nibble_sel = 4'h0;
    lz_sel     = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        an_sel[i]  = 1'b0;
        nibble_sel = hold_q[4*i +: 4];
        lz_sel     = (i != 0) && !nz_from[i];
      end
    end
  end

  hex_to_seg u_hex_to_seg (
    .nibble (nibble_sel),
    .seg    (dec_seg)
  );

  // Outputs are registered from the current state, so they trail it by one edge.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    hold_d  = load ? data_in : hold_q;
    seg_d   = SEG_OFF;
    an_d    = '1;
    frame_d = 1'b0;

    case (state_q)
      BLANK: begin
        state_d = SHOW;
        cnt_d   = '0;
      end
      SHOW: begin
        an_d    = an_sel;
        seg_d   = (blank_lz && lz_sel) ? SEG_OFF : dec_seg;
        frame_d = (idx_q == '0) && (cnt_q == '0);
        if (cnt_q == CNT_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = BLANK;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BLANK;
      idx_q   <= '0;
      cnt_q   <= '0;
      // NOTE: hold is a plain register, not a memory array, so it takes a reset value.
      hold_q  <= '0;
      seg_q   <= SEG_OFF;
      an_q    <= '1;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      frame_q <= frame_d;
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver with CLK_DIV=4, NUM_DIGITS=8.
module tb_seg_scan_driver;

  localparam int CLK_DIV    = 4;
  localparam int NUM_DIGITS = 8;

  logic        clk;
  logic        reset;
  logic [31:0] data_in;
  logic        load;
  logic        blank_lz;
  logic [7:0]  seg;
  logic [7:0]  an;
  logic        frame;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    logic        blz;
    logic [63:0] segs;   // digit 0 in the low byte
  } vec_t;

  typedef struct packed {
    logic [7:0] an;
    logic [7:0] seg;
    logic       frame;
  } exp_t;

  vec_t vecs [6];
  exp_t sb [$];

  seg_scan_driver #(.CLK_DIV(CLK_DIV), .NUM_DIGITS(NUM_DIGITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .load     (load),
    .blank_lz (blank_lz),
    .seg      (seg),
    .an       (an),
    .frame    (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] s, input logic f);
    exp_t e;
    e.an = a;
    e.seg = s;
    e.frame = f;
    sb.push_back(e);
  endtask

  task automatic compare(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty, got an=%h seg=%h", name, an, seg);
    end else begin
      e = sb.pop_front();
      check({name, "_an"}, 32'(an), 32'(e.an));
      check({name, "_seg"}, 32'(seg), 32'(e.seg));
      check({name, "_frame"}, 32'(frame), 32'(e.frame));
    end
  endtask

  task automatic step(input string name);
    @(negedge clk);
    compare(name);
  endtask

  task automatic do_load(input logic [31:0] d, input logic blz);
    @(negedge clk);
    data_in  = d;
    blank_lz = blz;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  task automatic wait_frame();
    bit found;
    found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      @(negedge clk);
      if (frame === 1'b1) found = 1'b1;
    end
    if (!found) check("frame_timeout", 32'd0, 32'd1);
  endtask

  // Releases reset and checks the blank cycle, digit 0 dwell, gap and digit 1 entry.
  task automatic release_reset(input string name);
    @(negedge clk);
    reset = 1'b1;
    push(8'hFF, 8'hFF, 1'b0);
    push(8'hFE, 8'hC0, 1'b1);
    for (int k = 0; k < 3; k++) push(8'hFE, 8'hC0, 1'b0);
    push(8'hFF, 8'hFF, 1'b0);
    push(8'hFD, 8'hC0, 1'b0);
    for (int k = 0; k < 7; k++) step(name);
  endtask

  initial begin
    vecs[0] = '{data: 32'h89AB_CDEF, blz: 1'b0, segs: 64'h8090_8883_C6A1_868E};
    vecs[1] = '{data: 32'h0000_0120, blz: 1'b1, segs: 64'hFFFF_FFFF_FFF9_A4C0};
    vecs[2] = '{data: 32'h0000_0000, blz: 1'b1, segs: 64'hFFFF_FFFF_FFFF_FFC0};
    vecs[3] = '{data: 32'h0000_0120, blz: 1'b0, segs: 64'hC0C0_C0C0_C0F9_A4C0};
    vecs[4] = '{data: 32'h1234_5670, blz: 1'b1, segs: 64'hF9A4_B099_9282_F8C0};
    vecs[5] = '{data: 32'h00F0_0000, blz: 1'b1, segs: 64'hFFFF_8EC0_C0C0_C0C0};

    reset    = 1'b0;
    load     = 1'b0;
    data_in  = '0;
    blank_lz = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_an", 32'(an), 32'h0000_00FF);
    check("rst_seg", 32'(seg), 32'h0000_00FF);
    check("rst_frame", 32'(frame), 32'd0);

    release_reset("first");

    // Full frames, plus the first cycle of the following frame to pin the 40-cycle period.
    for (int v = 0; v < 6; v++) begin
      logic [63:0] segs;
      segs = vecs[v].segs;
      do_load(vecs[v].data, vecs[v].blz);
      wait_frame();
      for (int d = 0; d < NUM_DIGITS; d++) begin
        for (int k = 0; k < CLK_DIV; k++)
          push(8'(~(8'd1 << d)), segs[8*d +: 8], (d == 0) && (k == 0));
        push(8'hFF, 8'hFF, 1'b0);
      end
      push(8'hFE, segs[7:0], 1'b1);
      compare($sformatf("vec%0d", v));
      while (sb.size() > 0) step($sformatf("vec%0d", v));
    end

    // Load mid-dwell: new word shows one cycle after capture, dwell unchanged.
    do_load(32'h0000_0005, 1'b0);
    wait_frame();
    push(8'hFE, 8'h92, 1'b1);
    compare("ld0");
    push(8'hFE, 8'h92, 1'b0);
    step("ld1");
    data_in = 32'h0000_0007;
    load    = 1'b1;
    push(8'hFE, 8'h92, 1'b0);
    step("ld2");
    load    = 1'b0;
    push(8'hFE, 8'hF8, 1'b0);
    step("ld3");
    push(8'hFF, 8'hFF, 1'b0);
    step("ld4");
    push(8'hFD, 8'hC0, 1'b0);
    step("ld5");

    // Asynchronous reset during digit 5, then restart with hold cleared.
    do_load(32'h89AB_CDEF, 1'b0);
    wait_frame();
    repeat (5 * (CLK_DIV + 1)) @(negedge clk);
    check("d5_an", 32'(an), 32'h0000_00DF);
    check("d5_seg", 32'(seg), 32'h0000_0088);
    #2 reset = 1'b0;
    #1;
    check("arst_an", 32'(an), 32'h0000_00FF);
    check("arst_seg", 32'(seg), 32'h0000_00FF);
    check("arst_frame", 32'(frame), 32'd0);
    @(negedge clk);
    release_reset("restart");

    // Random loads over three frames; at most one anode may be active.
    for (int c = 0; c < 3 * NUM_DIGITS * (CLK_DIV + 1); c++) begin
      @(negedge clk);
      check("onehot", 32'($countones(~an) <= 1), 32'd1);
      load     = 1'($urandom_range(0, 1));
      data_in  = $urandom;
      blank_lz = 1'($urandom_range(0, 1));
    end
    load = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Multiplexed eight-digit hex display driver that consumes the CPU output-port word (`OUT_unit_output`) and drives a common-anode seven-segment bank. It latches the 32-bit word on a strobe, scans one digit at a time with a programmable dwell, inserts a one-cycle blanking gap between digits to suppress ghosting, and optionally blanks leading zeros. It sits directly downstream of the output unit at the CPU top level, alongside `ram`.

## Interface

Parameters:
- `CLK_DIV`, 50000: clock cycles each digit stays lit; must be ≥2.
- `NUM_DIGITS`, 8: digits scanned; nibble *i* of the held word drives digit *i*; must be 1..8.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `data_in`  in  32  output-port word from the CPU.
- `load`  in  1  strobe; `data_in` is captured on every rising edge with `load`=1.
- `blank_lz`  in  1  1 = leading-zero blanking enabled.
- `seg`  out  8  active-low segments {dp,g,f,e,d,c,b,a}; dp is always off (1).
- `an`  out  NUM_DIGITS  active-low digit enables; at most one bit is 0 at any time.
- `frame`  out  1  one-cycle pulse on the edge where digit 0 is entered.

## Operation

- Hold register `hold[31:0]`:
  - Reset value 0.
  - Loads `data_in` on any edge with `load`=1, regardless of FSM state.
  - `load` held high reloads every cycle.
- FSM states BLANK and SHOW. Digit index `idx` runs 0..NUM_DIGITS-1. Dwell counter `cnt` is $clog2(CLK_DIV) bits wide.
  - Reset: BLANK, `idx`=0, `cnt`=0.
  - BLANK always lasts exactly 1 cycle, then goes to SHOW with `cnt`=0.
  - SHOW increments `cnt`. When `cnt`=CLK_DIV-1, it goes to BLANK, `cnt` returns to 0, and `idx` advances: `idx`=NUM_DIGITS-1 wraps to 0, otherwise `idx`+1.
- Outputs are registered.
  - In BLANK: `an`=all 1, `seg`=8'hFF.
  - In SHOW: `an[idx]`=0 and all other bits 1; `seg`=decode(`hold[4*idx+3:4*idx]`).
- Decode is standard hex 0-F. Lowercase b and d; A, C, E, F uppercase.
- Leading-zero blanking: with `blank_lz`=1, digit *i*>0 shows `seg`=8'hFF (its `an` bit is still driven low) when nibbles *i*..NUM_DIGITS-1 of `hold` are all zero. Digit 0 is never blanked, so a value of 0 shows a single "0".
- `blank_lz` is sampled live, with no latching.
- `frame`=1 for exactly the cycle in which SHOW is entered with `idx`=0.

## Timing

- Reset values while `reset`=0: `seg`=8'hFF, `an`=all 1, `frame`=0, `hold`=0. Reset takes effect immediately, without waiting for a clock edge, including mid-frame and mid-dwell.
- First edge after reset release: BLANK, outputs still off.
- Second edge after reset release: SHOW with digit 0, `frame`=1.
- Digit period is CLK_DIV+1 cycles. Frame period is NUM_DIGITS·(CLK_DIV+1) cycles.
- Load latency: if `load` is sampled at edge N, `hold` updates at N and `seg` reflects the new value from edge N+1 (when in SHOW). A load at the last SHOW cycle of a digit does not extend the dwell.
- Simultaneous `load` and a digit advance both take effect. The next digit's first SHOW cycle uses the new `hold`.
- No two `an` bits are ever low together. The BLANK cycle guarantees this across every transition, including the NUM_DIGITS-1 → 0 wrap.

## Structure

- Shared package `seg_pkg`:
  - constants `SEG_OFF`=8'hFF and `SEG_HEX[0:15]` (active-low patterns);
  - FSM state typedef `scan_state_t` {BLANK, SHOW}.
- One sub-module, `hex_to_seg` (4-bit in, 8-bit active-low out, combinational, dp=1). It is instantiated once and fed by an `idx`-selected nibble mux.
- The leading-zero mask is a combinational prefix-OR over nibbles from the MSB down.

## Test plan

- Reset/first frame (CLK_DIV=4, NUM_DIGITS=8): release reset → edge 1 `an`=8'hFF; edge 2 `an`=8'hFE, `seg`=8'hC0 ("0"), `frame`=1; `an` stays 8'hFE for 4 cycles, then 1 cycle 8'hFF, then 8'hFD.
- Full scan: load 32'h89ABCDEF, `blank_lz`=0 → digits 0..7 show F,E,d,C,b,A,9,8, i.e. `seg` 8E,86,A1,C6,83,88,90,80. Frame period 40 cycles.
- Leading-zero blanking: load 32'h0000_0120, `blank_lz`=1 → digits 0-2 show 0,2,1 and digits 3-7 give `seg`=FF. Load 0 → only digit 0 shows C0.
- Load mid-dwell: load 32'h5 then 32'h7 during digit 0's 2nd SHOW cycle → `seg` changes 92→F8 exactly one cycle later, and dwell still ends on schedule.
- Reset mid-operation: assert `reset` during SHOW of digit 5 → `an`=all 1, `seg`=FF immediately; after release, scanning restarts at digit 0 with `hold`=0.
- One-hot assertion: over 3 frames with random `load`/`data_in`, `an` is never driven with two zero bits.
